// File: rtl/multi_pwm_pkg.sv
// Shared constants, types and helpers for the multi-channel PWM peripheral.
// Polarity registers exist only when PWM_POLARITY_EN is defined.
package multi_pwm_pkg;

    localparam int unsigned ADDR_W = 7;
    localparam int unsigned DATA_W = 8;

    typedef logic [DATA_W-1:0] duty_t;

    localparam logic [ADDR_W-1:0] ADDR_OUT_EN_BASE = 7'h00;
    localparam logic [ADDR_W-1:0] ADDR_PWM_EN_BASE = 7'h04;
    localparam logic [ADDR_W-1:0] ADDR_PRESCALE    = 7'h08;
    localparam logic [ADDR_W-1:0] ADDR_PERIOD      = 7'h09;
    localparam logic [ADDR_W-1:0] ADDR_POL_BASE    = 7'h0C;
    localparam logic [ADDR_W-1:0] ADDR_DUTY_BASE   = 7'h20;

    localparam duty_t PERIOD_RST = 8'hFF;
    localparam duty_t DUTY_FULL  = 8'hFF;
    localparam duty_t CNT_MAX    = 8'hFF;

    // Full-scale duty forces the output high even when cnt reaches 0xFF.
    function automatic logic pwm_level(input duty_t cnt, input duty_t duty);
        return (duty == DUTY_FULL) || (cnt < duty);
    endfunction

endpackage

// File: rtl/pwm_timebase.sv
// Shared PWM timebase: programmable prescaler feeding an 8-bit period counter.
// wrap_c marks the last tick of a period (cnt returns to 0 on the next edge).
module pwm_timebase
    import multi_pwm_pkg::*;
#(
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] prescale,
    input  logic [DATA_W-1:0] period_top,
    output duty_t             cnt,
    output logic              wrap_c
);

    logic [PRESCALE_W-1:0] presc_cnt;
    logic                  tick_c;

    assign tick_c = (presc_cnt == PRESCALE_W'(prescale));

    // A top lowered below cnt is skipped; the counter then wraps at 0xFF.
    assign wrap_c = tick_c && ((cnt == period_top) || (cnt == CNT_MAX));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_cnt <= '0;
        end else if (tick_c) begin
            presc_cnt <= '0;
        end else begin
            presc_cnt <= presc_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (wrap_c) begin
            cnt <= '0;
        end else if (tick_c) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multi_pwm_peripheral.sv
// NUM_CH-output PWM peripheral with shared timebase and period-aligned duty shadowing.
// Optional per-channel output polarity is built when PWM_POLARITY_EN is defined.
module multi_pwm_peripheral
    import multi_pwm_pkg::*;
#(
    parameter int unsigned NUM_CH     = 16,
    parameter int unsigned PRESCALE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0] out,
    output logic              period_start
);

    logic              out_en_wr_c;
    logic              pwm_en_wr_c;
    logic              prescale_wr_c;
    logic              period_wr_c;
    logic              duty_wr_c;
    logic [DATA_W-1:0] prescale;
    logic [DATA_W-1:0] period_top;
    duty_t             cnt;
    logic              wrap_c;

    // Byte-lane register groups decode on the upper address bits.
    assign out_en_wr_c   = wr_en && (wr_addr[6:2] == ADDR_OUT_EN_BASE[6:2]);
    assign pwm_en_wr_c   = wr_en && (wr_addr[6:2] == ADDR_PWM_EN_BASE[6:2]);
    assign prescale_wr_c = wr_en && (wr_addr == ADDR_PRESCALE);
    assign period_wr_c   = wr_en && (wr_addr == ADDR_PERIOD);
    assign duty_wr_c     = wr_en && (wr_addr[6:5] == ADDR_DUTY_BASE[6:5]);

`ifdef PWM_POLARITY_EN
    logic pol_wr_c;
    assign pol_wr_c = wr_en && (wr_addr[6:2] == ADDR_POL_BASE[6:2]);
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale   <= '0;
            period_top <= PERIOD_RST;
        end else begin
            if (prescale_wr_c) begin
                prescale <= wr_data;
            end
            if (period_wr_c) begin
                period_top <= wr_data;
            end
        end
    end

    pwm_timebase #(
        .PRESCALE_W (PRESCALE_W)
    ) u_timebase (
        .clk        (clk),
        .rst_n      (rst_n),
        .prescale   (prescale),
        .period_top (period_top),
        .cnt        (cnt),
        .wrap_c     (wrap_c)
    );

    // Pulse lands in the first cycle of the new period (cnt == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            period_start <= 1'b0;
        end else begin
            period_start <= wrap_c;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam int unsigned BYTE_IDX = g / 8;
        localparam int unsigned BIT_IDX  = g % 8;

        logic  out_en_q;
        logic  pwm_en_q;
        duty_t duty_q;
        duty_t duty_shadow_q;
        logic  out_q;
        logic  pol_c;
        logic  pwm_c;
        logic  out_nxt_c;

`ifdef PWM_POLARITY_EN
        logic pol_q;

        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                pol_q <= 1'b0;
            end else if (pol_wr_c && (wr_addr[1:0] == 2'(BYTE_IDX))) begin
                pol_q <= wr_data[BIT_IDX];
            end
        end

        assign pol_c = pol_q;
`else
        assign pol_c = 1'b0;
`endif

        // Shadow copy takes the pre-write duty, so a write on the wrap edge waits a period.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                out_en_q      <= 1'b0;
                pwm_en_q      <= 1'b0;
                duty_q        <= '0;
                duty_shadow_q <= '0;
                out_q         <= 1'b0;
            end else begin
                if (out_en_wr_c && (wr_addr[1:0] == 2'(BYTE_IDX))) begin
                    out_en_q <= wr_data[BIT_IDX];
                end
                if (pwm_en_wr_c && (wr_addr[1:0] == 2'(BYTE_IDX))) begin
                    pwm_en_q <= wr_data[BIT_IDX];
                end
                if (duty_wr_c && (wr_addr[4:0] == 5'(g))) begin
                    duty_q <= wr_data;
                end
                if (wrap_c) begin
                    duty_shadow_q <= duty_q;
                end
                out_q <= out_nxt_c;
            end
        end

        assign pwm_c = pwm_level(cnt, duty_shadow_q);

        always_comb begin
            out_nxt_c = 1'b0;
            if (out_en_q) begin
                out_nxt_c = pwm_en_q ? (pwm_c ^ pol_c) : 1'b1;
            end
        end

        assign out[g] = out_q;
    end

endmodule

// File: tb/tb_multi_pwm_peripheral.sv
// Scoreboard bench for multi_pwm_peripheral: a cycle reference model queues the
// expected {period_start, out} per clock; a monitor pops and compares on negedges.
module tb_multi_pwm_peripheral;

    localparam int NUM_CH     = 16;
    localparam int PRESCALE_W = 8;

    typedef logic [NUM_CH:0] exp_t;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              wr_en = 1'b0;
    logic [6:0]        wr_addr = '0;
    logic [7:0]        wr_data = '0;
    logic [NUM_CH-1:0] out;
    logic              period_start;

    multi_pwm_peripheral #(
        .NUM_CH     (NUM_CH),
        .PRESCALE_W (PRESCALE_W)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .wr_en        (wr_en),
        .wr_addr      (wr_addr),
        .wr_data      (wr_data),
        .out          (out),
        .period_start (period_start)
    );

    always #5 clk = ~clk;

    int   n_vec = 0;
    int   n_err = 0;
    int   cyc = 0;
    exp_t sb_q[$];

    // Reference model state (plain integers)
    int m_presc, m_cnt, m_pre, m_top;
    bit m_oe[32];
    bit m_pe[32];
    bit m_pol[32];
    int m_duty[32];
    int m_shadow[32];
    bit m_wrap_now;

    function automatic void model_reset();
        m_presc = 0; m_cnt = 0; m_pre = 0; m_top = 255; m_wrap_now = 1'b0;
        for (int i = 0; i < 32; i++) begin
            m_oe[i] = 0; m_pe[i] = 0; m_pol[i] = 0; m_duty[i] = 0; m_shadow[i] = 0;
        end
    endfunction

    function automatic void model_write(input int a, input int d);
        for (int b = 0; b < 8; b++) begin
            if (a < 4 && a * 8 + b < NUM_CH) m_oe[a * 8 + b] = bit'((d >> b) & 1);
            if (a >= 4 && a < 8 && (a - 4) * 8 + b < NUM_CH) m_pe[(a - 4) * 8 + b] = bit'((d >> b) & 1);
`ifdef PWM_POLARITY_EN
            if (a >= 12 && a < 16 && (a - 12) * 8 + b < NUM_CH) m_pol[(a - 12) * 8 + b] = bit'((d >> b) & 1);
`endif
        end
        if (a == 8) m_pre = d;
        if (a == 9) m_top = d;
        if (a >= 32 && a - 32 < NUM_CH) m_duty[a - 32] = d;
    endfunction

    function automatic logic [NUM_CH-1:0] model_out();
        logic [NUM_CH-1:0] v;
        bit p;
        v = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            p = (m_shadow[i] == 255) || (m_cnt < m_shadow[i]);
            if (!m_oe[i])      v[i] = 1'b0;
            else if (!m_pe[i]) v[i] = 1'b1;
            else               v[i] = p ^ m_pol[i];
        end
        return v;
    endfunction

    // Reference model: one step per clock edge, flushes on asynchronous reset.
    initial begin
        bit   prev_rst;
        bit   tick, wrap;
        exp_t e;
        prev_rst = 1'b0;
        model_reset();
        forever begin
            @(posedge clk or negedge rst_n);
            if (!rst_n) begin
                if (prev_rst) begin
                    sb_q.delete();
                end else begin
                    cyc++;
                    sb_q.push_back('0);
                end
                model_reset();
            end else begin
                cyc++;
                e[NUM_CH-1:0] = model_out();
                tick = (m_presc == m_pre);
                wrap = tick && (m_cnt == m_top || m_cnt == 255);
                e[NUM_CH] = wrap;
                if (wrap) for (int i = 0; i < 32; i++) m_shadow[i] = m_duty[i];
                m_presc = tick ? 0 : (m_presc + 1) % (1 << PRESCALE_W);
                m_cnt   = wrap ? 0 : (tick ? m_cnt + 1 : m_cnt);
                if (wr_en) model_write(int'(wr_addr), int'(wr_data));
                sb_q.push_back(e);
                m_wrap_now = (m_presc == m_pre) && (m_cnt == m_top || m_cnt == 255);
            end
            prev_rst = rst_n;
        end
    end

    // Monitor: compare every presented cycle against the queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                n_vec++;
                if ({period_start, out} !== e) begin
                    n_err++;
                    $display("FAIL scoreboard cyc=%0d got out=%h ps=%b exp out=%h ps=%b",
                             cyc, out, period_start, e[NUM_CH-1:0], e[NUM_CH]);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input int got, input int exp);
        n_vec++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s got=%0d exp=%0d", name, got, exp);
        end
    endtask

    task automatic wr(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 7'(a);
        wr_data = 8'(d);
        @(posedge clk);
        #2;
        wr_en   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic sync_ps(output int c);
        c = -1;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            if (period_start) begin
                c = cyc;
                break;
            end
        end
        if (c < 0) chk("sync_ps_timeout", 0, 1);
    endtask

    task automatic measure_one(input int ch, output int hi, output int len);
        bit done;
        hi = 0; len = 0; done = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            @(negedge clk);
            len++;
            if (out[ch]) hi++;
            if (period_start) begin
                done = 1'b1;
                break;
            end
        end
        if (!done) chk("measure_timeout", 0, 1);
    endtask

    task automatic wait_wrap();
        bit found;
        found = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (m_wrap_now) begin
                found = 1'b1;
                break;
            end
            @(posedge clk);
            #2;
        end
        if (!found) chk("wait_wrap_timeout", 0, 1);
    endtask

    initial begin
        int c0, c, hi, len, kind, a, d;

        // Writes while in reset must be ignored.
        idle(1);
        wr(0, 8'hFF);
        wr(4, 8'hFF);
        wr(8'h20, 8'h80);
        @(posedge clk);
        #2;
        rst_n = 1'b1;
        c0 = cyc;
        sync_ps(c);
        chk("first_period_start_delay", c - c0, 256);

        // Static outputs
        wr(0, 8'h05);
        @(posedge clk);
        @(negedge clk);
        chk("static_out", int'(out), 5);

        // Duty on channel 1 with default timebase
        wr(0, 8'h07);
        wr(4, 8'h02);
        wr(8'h21, 8'h40);
        sync_ps(c);
        measure_one(1, hi, len);
        chk("duty40_high", hi, 64);
        chk("duty40_period", len, 256);
        wr(8'h21, 8'h00);
        sync_ps(c);
        measure_one(1, hi, len);
        chk("duty00_high", hi, 0);
        wr(8'h21, 8'hFF);
        sync_ps(c);
        measure_one(1, hi, len);
        chk("dutyFF_high", hi, 256);

        // Prescale 3, top 9, duty 5 on channel 0
        wr(8, 3);
        wr(9, 9);
        wr(4, 8'h03);
        wr(8'h20, 5);
        sync_ps(c);
        measure_one(0, hi, len);
        chk("presc_high", hi, 20);
        chk("presc_period", len, 40);
        measure_one(0, hi, len);
        chk("presc_period_repeat", len, 40);

        // Shadowing: mid-period write vs write on the wrap edge
        wr(8, 0);
        wr(9, 255);
        wr(8'h20, 8'h10);
        sync_ps(c);
        idle(50);
        wr(8'h20, 8'h80);
        sync_ps(c);
        measure_one(0, hi, len);
        chk("shadow_midperiod", hi, 128);
        wait_wrap();
        wr(8'h20, 8'h20);
        sync_ps(c);
        measure_one(0, hi, len);
        chk("shadow_wrapwrite_held", hi, 128);
        measure_one(0, hi, len);
        chk("shadow_wrapwrite_applied", hi, 32);

`ifdef PWM_POLARITY_EN
        wr(8'h0C, 8'h02);
        wr(8'h21, 8'h40);
        wr(4, 8'h03);
        sync_ps(c);
        measure_one(1, hi, len);
        chk("polarity_high", hi, 192);
        wr(4, 8'h01);
        idle(2);
        chk("polarity_static", int'(out[1]), 1);
`endif

        // Randomised register traffic, checked cycle by cycle
        for (int n = 0; n < 300; n++) begin
            kind = int'($urandom_range(0, 7));
            d = int'($urandom_range(0, 255));
            case (kind)
                0: a = int'($urandom_range(0, 3));
                1: a = int'($urandom_range(4, 7));
                2: begin a = 8; d = int'($urandom_range(0, 3)); end
                3: begin a = 9; d = ($urandom_range(0, 1) != 0) ? int'($urandom_range(2, 40)) : d; end
                4: a = int'($urandom_range(12, 15));
                5, 6: a = 32 + int'($urandom_range(0, 31));
                default: a = int'($urandom_range(0, 127));
            endcase
            wr(a, d);
            idle(int'($urandom_range(0, 6)));
        end

        // Mid-period reset restores defaults
        rst_n = 1'b0;
        wr(0, 8'hFF);
        idle(2);
        rst_n = 1'b1;
        c0 = cyc;
        sync_ps(c);
        chk("reset_midperiod_first_ps", c - c0, 256);
        idle(20);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
